// File: rtl/alu_regfile_seq.sv
// Register file and instruction sequencer for the 4-entry, 16-bit add/multiply ALU.
// It accepts one instruction at a time and writes the ALU results back into the register file.
module alu_regfile_seq #(
  parameter int               WIDTH   = 16,
  parameter int               NREG    = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
  // The source holds valid and the fields stable until that edge. While busy, ready is
  // low and valid is ignored.
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_opc,
  input  logic             instr_sig,
  input  logic [1:0]       instr_rs1,
  input  logic [1:0]       instr_rs2,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rd_hi,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] R [NREG],
  output logic [1:0]       select1_reg,
  output logic [1:0]       select2_reg,
  output logic             sig,
  output logic             op,
  input  logic [WIDTH-1:0] alu_out1,
  input  logic [WIDTH-1:0] alu_out2,
  input  logic             alu_flag,
  output logic             flag_q,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_MUL = 2'b01;
  localparam logic [1:0] OPC_LDI = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB_HI = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] hi_buf;
  logic [1:0]       lat_opc, lat_rs1, lat_rs2, lat_rd, lat_rd_hi;
  logic             lat_sig;
  logic [WIDTH-1:0] lat_imm;
  logic             accept;

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = (lat_opc == OPC_MUL) ? WB_HI : IDLE;
      WB_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && rst_n;
    busy        = (state != IDLE);
    // op stays high through WB_HI so the ALU output does not change under the high-half write.
    op          = ((state == EXEC) && (lat_opc == OPC_MUL)) || (state == WB_HI);
  end

  assign select1_reg = lat_rs1;
  assign select2_reg = lat_rs2;
  assign sig         = lat_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
      lat_opc   <= '0;
      lat_sig   <= 1'b0;
      lat_rs1   <= '0;
      lat_rs2   <= '0;
      lat_rd    <= '0;
      lat_rd_hi <= '0;
      lat_imm   <= '0;
      hi_buf    <= '0;
      flag_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        lat_opc   <= instr_opc;
        lat_sig   <= instr_sig;
        lat_rs1   <= instr_rs1;
        lat_rs2   <= instr_rs2;
        lat_rd    <= instr_rd;
        lat_rd_hi <= instr_rd_hi;
        lat_imm   <= instr_imm;
      end
      case (state)
        EXEC: begin
          case (lat_opc)
            OPC_ADD: begin
              regs[lat_rd] <= alu_out1;
              flag_q       <= alu_flag;
              done         <= 1'b1;
            end
            OPC_MUL: begin
              regs[lat_rd] <= alu_out1;
              hi_buf       <= alu_out2;
            end
            OPC_LDI: begin
              regs[lat_rd] <= lat_imm;
              done         <= 1'b1;
            end
            default: done <= 1'b1;
          endcase
        end
        WB_HI: begin
          regs[lat_rd_hi] <= hi_buf;
          done            <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign R        = regs;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: a combinational ALU drives the DUT, and a register-file
// reference model with a result queue predicts every writeback.
module tb_alu_regfile_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_opc;
  logic        instr_sig;
  logic [1:0]  instr_rs1, instr_rs2, instr_rd, instr_rd_hi;
  logic [15:0] instr_imm;
  logic [15:0] r [4];
  logic [1:0]  select1_reg, select2_reg;
  logic        sig, op;
  logic [15:0] alu_out1, alu_out2;
  logic        alu_flag;
  logic        flag_q, busy, done;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_r [4];
  logic        ref_flag;
  logic [15:0] exp_q [$];
  logic [1:0]  last_opc, last_rd, last_rdh;
  logic [15:0] old_hi;

  alu_regfile_seq #(.WIDTH(16), .NREG(4), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opc(instr_opc), .instr_sig(instr_sig),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_rd(instr_rd), .instr_rd_hi(instr_rd_hi), .instr_imm(instr_imm),
    .R(r), .select1_reg(select1_reg), .select2_reg(select2_reg),
    .sig(sig), .op(op),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_flag(alu_flag),
    .flag_q(flag_q), .busy(busy), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU environment ----------------
  logic [15:0] alu_a, alu_b;
  logic [16:0] alu_sum;
  logic [31:0] alu_prod;

  always_comb begin
    alu_a   = r[select1_reg];
    alu_b   = r[select2_reg];
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    if (sig) alu_prod = $signed({{16{alu_a[15]}}, alu_a}) * $signed({{16{alu_b[15]}}, alu_b});
    else     alu_prod = {16'h0, alu_a} * {16'h0, alu_b};
    if (op) begin
      alu_out1 = alu_prod[15:0];
      alu_out2 = alu_prod[31:16];
      alu_flag = 1'b0;
    end else begin
      alu_out1 = alu_sum[15:0];
      alu_out2 = 16'h0;
      alu_flag = sig ? ((alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15])) : alu_sum[16];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reg%0d", i), 32'(r[i]), 32'(ref_r[i]));
      dbg_addr = 2'(i);
      #1;
      check($sformatf("dbg%0d", i), 32'(dbg_data), 32'(ref_r[i]));
    end
    check("flag_q", 32'(flag_q), 32'(ref_flag));
  endtask

  // ---------------- reference model ----------------
  task automatic model_apply(input logic [1:0] opc, input logic sg, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [1:0] rd, input logic [1:0] rdh,
                             input logic [15:0] imm);
    longint x, y, s;
    logic [63:0] p;
    x = sg ? longint'($signed(ref_r[rs1])) : longint'(ref_r[rs1]);
    y = sg ? longint'($signed(ref_r[rs2])) : longint'(ref_r[rs2]);
    case (opc)
      2'b00: begin
        s = x + y;
        ref_flag = sg ? (s > 32767 || s < -32768) : (s > 65535);
        p = 64'(s);
        ref_r[rd] = p[15:0];
        exp_q.push_back(p[15:0]);
      end
      2'b01: begin
        p = 64'(x * y);
        ref_r[rd]  = p[15:0];
        ref_r[rdh] = p[31:16];
        exp_q.push_back(p[15:0]);
        exp_q.push_back(p[31:16]);
      end
      2'b10: begin
        ref_r[rd] = imm;
        exp_q.push_back(imm);
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start(input logic [1:0] opc, input logic sg, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [1:0] rd, input logic [1:0] rdh,
                       input logic [15:0] imm);
    int waited;
    instr_valid = 1'b1;
    instr_opc = opc; instr_sig = sg; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_rd = rd; instr_rd_hi = rdh; instr_imm = imm;
    waited = 0;
    while (!instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(instr_ready), 32'h1);
    old_hi = ref_r[rdh];
    last_opc = opc; last_rd = rd; last_rdh = rdh;
    model_apply(opc, sg, rs1, rs2, rd, rdh, imm);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_opc = 2'($urandom); instr_sig = 1'($urandom); instr_rs1 = 2'($urandom);
    instr_rs2 = 2'($urandom); instr_rd = 2'($urandom); instr_rd_hi = 2'($urandom);
    instr_imm = 16'($urandom);
    check("exec_busy", 32'(busy), 32'h1);
    check("exec_ready", 32'(instr_ready), 32'h0);
    check("exec_done", 32'(done), 32'h0);
    check("exec_sel1", 32'(select1_reg), 32'(rs1));
    check("exec_sel2", 32'(select2_reg), 32'(rs2));
    check("exec_sig", 32'(sig), 32'(sg));
    check("exec_op", 32'(op), 32'(opc == 2'b01));
  endtask

  task automatic finish();
    int n;
    logic [15:0] lo, hi;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (last_opc == 2'b01 && n == 1) begin
        check("wbhi_ready", 32'(instr_ready), 32'h0);
        check("wbhi_busy", 32'(busy), 32'h1);
        check("wbhi_op", 32'(op), 32'h1);
        check("mul_lo_early", 32'(r[last_rd]), 32'(exp_q.size() != 0 ? exp_q[0] : 16'hxxxx));
        if (last_rd != last_rdh) check("mul_hi_not_yet", 32'(r[last_rdh]), 32'(old_hi));
      end
    end while (!done && n < 8);
    check("latency", 32'(n), (last_opc == 2'b01) ? 32'd2 : 32'd1);
    check("done_ready", 32'(instr_ready), 32'h1);
    if (last_opc == 2'b01) begin
      check("q_depth_mul", 32'(exp_q.size() >= 2), 32'h1);
      lo = exp_q.pop_front();
      hi = exp_q.pop_front();
      check("mul_hi", 32'(r[last_rdh]), 32'(hi));
      if (last_rd != last_rdh) check("mul_lo", 32'(r[last_rd]), 32'(lo));
    end else if (last_opc != 2'b11) begin
      check("q_depth", 32'(exp_q.size() >= 1), 32'h1);
      lo = exp_q.pop_front();
      check("result", 32'(r[last_rd]), 32'(lo));
    end
    check_all();
  endtask

  task automatic do_instr(input logic [1:0] opc, input logic sg, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [1:0] rd, input logic [1:0] rdh,
                          input logic [15:0] imm);
    start(opc, sg, rs1, rs2, rd, rdh, imm);
    finish();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_opc = 2'b11; instr_sig = 1'b0;
    instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_rd = 2'd0; instr_rd_hi = 2'd0;
    instr_imm = 16'h0; dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) ref_r[i] = 16'h0;
    ref_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sel1", 32'(select1_reg), 32'h0);
    check("rst_sel2", 32'(select2_reg), 32'h0);
    check("rst_sig_op", 32'({sig, op}), 32'h0);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'h1);

    // unsigned add with carry out
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0001);
    do_instr(2'b00, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 16'h0);
    check("t1_r2", 32'(r[2]), 32'h0000);
    check("t1_flag", 32'(flag_q), 32'h1);

    // signed overflow, then no overflow
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'h7FFF);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0001);
    do_instr(2'b00, 1'b1, 2'd0, 2'd1, 2'd2, 2'd0, 16'h0);
    check("t2_r2a", 32'(r[2]), 32'h8000);
    check("t2_flag_a", 32'(flag_q), 32'h1);
    do_instr(2'b00, 1'b1, 2'd1, 2'd1, 2'd2, 2'd0, 16'h0);
    check("t2_r2b", 32'(r[2]), 32'h0002);
    check("t2_flag_b", 32'(flag_q), 32'h0);

    // unsigned multiply into two destinations
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'h1234);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0100);
    do_instr(2'b01, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 16'h0);
    check("t3_r2", 32'(r[2]), 32'h3400);
    check("t3_r3", 32'(r[3]), 32'h0012);
    check("t3_flag", 32'(flag_q), 32'h0);

    // signed multiply overwriting its own sources
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0002);
    do_instr(2'b01, 1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 16'h0);
    check("t4_r0", 32'(r[0]), 32'hFFFE);
    check("t4_r1", 32'(r[1]), 32'hFFFF);

    // ADD held valid during a MUL: accepted only in the done cycle, executed once
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0003);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0005);
    start(2'b01, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 16'h0);
    instr_valid = 1'b1; instr_opc = 2'b00; instr_sig = 1'b0;
    instr_rs1 = 2'd2; instr_rs2 = 2'd1; instr_rd = 2'd0; instr_rd_hi = 2'd3; instr_imm = 16'h0;
    finish();
    check("t5_done_with_ready", 32'(done), 32'h1);
    start(2'b00, 1'b0, 2'd2, 2'd1, 2'd0, 2'd3, 16'h0);
    finish();
    check("t5_r0", 32'(r[0]), 32'h0014);
    repeat (3) begin
      @(negedge clk);
      check("t5_once_done", 32'(done), 32'h0);
      check("t5_once_busy", 32'(busy), 32'h0);
    end
    check("t5_r0_stable", 32'(r[0]), 32'h0014);

    // random instruction mix
    for (int k = 0; k < 40; k++) begin
      do_instr(2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'($urandom),
               2'($urandom), 2'($urandom), 16'($urandom));
    end

    // reset during the high-half writeback
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h0001);
    do_instr(2'b00, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 16'h0);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h7FFF);
    start(2'b01, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 16'h0);
    @(negedge clk);
    check("t6_in_wbhi", 32'(busy), 32'h1);
    check("t6_flag_before", 32'(flag_q), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) ref_r[i] = 16'h0;
    ref_flag = 1'b0;
    exp_q.delete();
    check("t6_done", 32'(done), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_ready_in_rst", 32'(instr_ready), 32'h0);
    check("t6_op", 32'(op), 32'h0);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_after", 32'(instr_ready), 32'h1);
    check("t6_regs_hold", 32'(r[3]), 32'h0);
    do_instr(2'b10, 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 16'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
